calc_key_entry: RTL
===================

Name: calc_key_entry

Overview:
- Front-end input sequencer for the calculator.
- Accepts one-cycle key events (digits, operators, equals, clear) and assembles two signed 8-bit operands and a 2-bit opcode.
- On "=", presents A, B and opcode to the ALU with a one-cycle commit strobe.
- Drives entry_value so the existing result display can echo digits while they are being typed.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per operand (1..3).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key_valid  input  1  one-cycle strobe; key_code is sampled when high
- key_code  input  4  0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQ, 15 CLR
- result  input  16  signed ALU result; used only with CALC_CHAIN_EN
- A  output  8  signed operand A, registered
- B  output  8  signed operand B, registered
- opcode  output  2  00 add, 01 sub, 10 mul, 11 div, registered
- operands_valid  output  1  one-cycle pulse; A/B/opcode are committed this cycle
- entry_value  output  16  signed, sign-extended value currently being entered
- entry_state  output  2  00 S_A, 01 S_B, 10 S_DONE
- key_err  output  1  one-cycle pulse when a key is rejected

Behaviour:
- Reset: state S_A; A, B, opcode, entry_value, magnitude, digit count and sign flag all 0; operands_valid 0; key_err 0.
- Timing:
  - All outputs are registered.
  - A key sampled at edge N takes effect after edge N.
  - operands_valid and key_err are high for exactly the cycle following the accepting/rejecting edge.
  - Keys may arrive on consecutive cycles; each is processed independently.
- Per-operand working registers: mag (8-bit unsigned), ndig (digit count), neg (sign flag).
- entry_value = neg ? -mag : mag, sign-extended to 16 bits.
- Digit d (any entry state):
  - Accepted when ndig < MAX_DIGITS and mag*10+d <= (neg ? 128 : 127).
  - On accept: mag <= mag*10+d, ndig += 1.
  - Otherwise rejected: key_err pulses, state unchanged.
  - Leading zeros count as digits.
- SUB with ndig==0 and neg==0: sets neg (sign entry). SUB with ndig==0 and neg==1: rejected.
- S_A:
  - Operator (10-13) with ndig>=1: latch pending opcode; hold signed A value internally; clear mag/ndig/neg; go to S_B.
  - Operator with ndig==0 (other than sign SUB): rejected.
  - EQ: rejected.
- S_B:
  - Operator with ndig>=1: rejected. SUB with ndig==0 is the sign for B.
  - EQ with ndig>=1: A, B, opcode registered; operands_valid pulse; go to S_DONE; entry_value keeps B.
  - EQ with ndig==0: rejected.
- S_DONE:
  - Digit: clear all working state; start new A with that digit (subject to the limit rule); go to S_A.
  - SUB: clear working state; set neg; go to S_A.
  - EQ: re-assert operands_valid with unchanged A/B/opcode.
  - ADD/MUL/DIV: rejected (without the optional feature).
- CLR in any state (also while sign-only): behaves as reset on the next edge, including A/B/opcode; no key_err.
- key_code sampled only when key_valid=1; otherwise ignored.
- rst has priority over any key on the same edge.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined:
  - In S_DONE, any operator key loads the pending A with result saturated to [-128,127].
  - entry_value shows the saturated value; opcode is latched; B working state is cleared; go to S_B.
  - SUB acts as an operator in this case, not as a sign.
- Undefined:
  - result port is unused.
  - Operators in S_DONE behave as stated in Behaviour.

Test Plan:
- Keys 9, ADD(10), 8, EQ(14) -> operands_valid one cycle; A=9, B=8, opcode=00; entry_state=S_DONE.
- Keys SUB, 1,2,8, MUL, SUB, 5, EQ -> A=-128, B=-5, opcode=10; entry_value=-5 after the 5 key.
- Keys 1,2,8 (positive) -> the 8 is rejected: key_err pulses, entry_value stays 12. Keys 1,0,0,7 with MAX_DIGITS=3 -> the 7 is rejected, entry_value=100.
- Edge rejections, all pulsing key_err with state unchanged: EQ in S_A; ADD with no digits; SUB,SUB in S_B.
- After a commit, key CLR -> next cycle A=B=opcode=0, entry_state=S_A, no operands_valid. Assert rst during S_B -> same reset values.
- With CALC_CHAIN_EN, after a commit with result=300: key ADD -> entry_value=127, entry_state=S_B. Keys 3, EQ -> A=127, B=3, opcode=00. Without the macro, the same ADD -> key_err pulse.

Source files
------------

// File: rtl/calc_key_entry_if.sv
// Key-entry bus for calc_key_entry: key events and chained ALU result
// in, committed operands and display echo out.
interface calc_key_entry_if;
    logic               key_valid;
    logic [3:0]         key_code;
    logic signed [15:0] result;
    logic signed [7:0]  A;
    logic signed [7:0]  B;
    logic [1:0]         opcode;
    logic               operands_valid;
    logic signed [15:0] entry_value;
    logic [1:0]         entry_state;
    logic               key_err;

    // Key source / ALU side
    modport master (
        output key_valid, key_code, result,
        input  A, B, opcode, operands_valid, entry_value, entry_state, key_err
    );

    // Sequencer side
    modport slave (
        input  key_valid, key_code, result,
        output A, B, opcode, operands_valid, entry_value, entry_state, key_err
    );
endinterface

// File: rtl/calc_key_entry.sv
// calc_key_entry: calculator key-entry sequencer.
// Assembles two signed 8-bit operands and an opcode from one-cycle key
// events and commits them to the ALU on "=". All outputs are registered.
// Optional macro CALC_CHAIN_EN: operator keys after a commit continue the
// calculation from the saturated ALU result.
module calc_key_entry #(
    parameter int MAX_DIGITS = 3
) (
    input logic             clk,
    input logic             rst,
    calc_key_entry_if.slave bus
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [3:0] {
        ACT_NONE,
        ACT_DIGIT,      // append digit to current operand
        ACT_SIGN,       // leading minus on current operand
        ACT_OPER,       // A finished, operator latched
        ACT_COMMIT,     // present A/B/opcode to the ALU
        ACT_RECOMMIT,   // repeat last commit
        ACT_NEW_DIGIT,  // start a fresh A with a digit after a commit
        ACT_NEW_SIGN,   // start a fresh negative A after a commit
        ACT_CHAIN,      // continue from ALU result
        ACT_CLR,        // full clear
        ACT_REJECT      // key not legal here
    } act_t;

    localparam logic [1:0] MAX_D = 2'(MAX_DIGITS);

    // Clamp a 16-bit signed ALU result into the 8-bit operand range.
    function automatic logic signed [7:0] sat_s8(input logic signed [15:0] v);
        if (v > 16'sd127)
            return 8'sd127;
        else if (v < -16'sd128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

    // Signed value of a sign/magnitude working operand, 16 bits wide.
    function automatic logic signed [15:0] entry_s16(input logic neg, input logic [7:0] mag);
        logic signed [15:0] m;
        m = {8'h00, mag};
        return neg ? -m : m;
    endfunction

    state_t             state_q, state_d;
    act_t               act;

    logic [7:0]         mag_q, mag_d;
    logic [1:0]         ndig_q, ndig_d;
    logic               neg_q, neg_d;
    logic signed [7:0]  pend_a_q, pend_a_d;
    logic [1:0]         pend_op_q, pend_op_d;
    logic signed [7:0]  a_q, a_d;
    logic signed [7:0]  b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic               ov_q, ov_d;
    logic               err_q, err_d;
    logic signed [15:0] ev_q, ev_d;

    logic               k_digit, k_op, k_sub, k_eq, k_clr;
    logic [11:0]        cand;
    logic               digit_ok;
    logic [1:0]         op_key;
    logic signed [15:0] work_s16;
    logic signed [7:0]  work_s8;

    assign k_digit  = (bus.key_code <= 4'd9);
    assign k_op     = (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
    assign k_sub    = (bus.key_code == 4'd11);
    assign k_eq     = (bus.key_code == 4'd14);
    assign k_clr    = (bus.key_code == 4'd15);
    assign op_key   = 2'(bus.key_code - 4'd10);

    // A negative operand may reach 128 so that -128 can be typed.
    assign cand     = 12'(mag_q) * 12'd10 + 12'(bus.key_code);
    assign digit_ok = (ndig_q < MAX_D) && (cand <= (neg_q ? 12'd128 : 12'd127));

    assign work_s16 = entry_s16(neg_q, mag_q);
    assign work_s8  = work_s16[7:0];

`ifndef CALC_CHAIN_EN
    logic unused_result;
    assign unused_result = ^bus.result;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_A;
        else
            state_q <= state_d;
    end

    // Next-state and key classification
    always_comb begin
        state_d = state_q;
        act     = ACT_NONE;
        if (bus.key_valid) begin
            if (k_clr) begin
                act     = ACT_CLR;
                state_d = S_A;
            end else begin
                case (state_q)
                    S_A: begin
                        if (k_digit)
                            act = digit_ok ? ACT_DIGIT : ACT_REJECT;
                        else if (k_sub && ndig_q == 2'd0)
                            act = neg_q ? ACT_REJECT : ACT_SIGN;
                        else if (k_op && ndig_q != 2'd0) begin
                            act     = ACT_OPER;
                            state_d = S_B;
                        end else
                            act = ACT_REJECT;
                    end
                    S_B: begin
                        if (k_digit)
                            act = digit_ok ? ACT_DIGIT : ACT_REJECT;
                        else if (k_sub && ndig_q == 2'd0)
                            act = neg_q ? ACT_REJECT : ACT_SIGN;
                        else if (k_eq && ndig_q != 2'd0) begin
                            act     = ACT_COMMIT;
                            state_d = S_DONE;
                        end else
                            act = ACT_REJECT;
                    end
                    S_DONE: begin
                        if (k_digit) begin
                            act     = ACT_NEW_DIGIT;
                            state_d = S_A;
                        end else if (k_eq)
                            act = ACT_RECOMMIT;
`ifdef CALC_CHAIN_EN
                        else if (k_op) begin
                            act     = ACT_CHAIN;
                            state_d = S_B;
                        end
`else
                        else if (k_sub) begin
                            act     = ACT_NEW_SIGN;
                            state_d = S_A;
                        end
`endif
                        else
                            act = ACT_REJECT;
                    end
                    default: begin
                        act     = ACT_CLR;
                        state_d = S_A;
                    end
                endcase
            end
        end
    end

    // Datapath and output next values for the chosen action
    always_comb begin
        mag_d     = mag_q;
        ndig_d    = ndig_q;
        neg_d     = neg_q;
        pend_a_d  = pend_a_q;
        pend_op_d = pend_op_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        ov_d      = 1'b0;
        err_d     = 1'b0;
        ev_d      = ev_q;
        case (act)
            ACT_DIGIT: begin
                mag_d  = cand[7:0];
                ndig_d = 2'(ndig_q + 2'd1);
                ev_d   = entry_s16(neg_d, mag_d);
            end
            ACT_SIGN: begin
                neg_d = 1'b1;
                ev_d  = entry_s16(neg_d, mag_d);
            end
            ACT_OPER: begin
                pend_a_d  = work_s8;
                pend_op_d = op_key;
                mag_d     = 8'd0;
                ndig_d    = 2'd0;
                neg_d     = 1'b0;
                ev_d      = 16'sd0;
            end
            ACT_COMMIT: begin
                a_d  = pend_a_q;
                b_d  = work_s8;
                op_d = pend_op_q;
                ov_d = 1'b1;
            end
            ACT_RECOMMIT: begin
                ov_d = 1'b1;
            end
            ACT_NEW_DIGIT: begin
                mag_d  = {4'h0, bus.key_code};
                ndig_d = 2'd1;
                neg_d  = 1'b0;
                ev_d   = entry_s16(neg_d, mag_d);
            end
            ACT_NEW_SIGN: begin
                mag_d  = 8'd0;
                ndig_d = 2'd0;
                neg_d  = 1'b1;
                ev_d   = 16'sd0;
            end
            ACT_CHAIN: begin
                pend_a_d  = sat_s8(bus.result);
                pend_op_d = op_key;
                mag_d     = 8'd0;
                ndig_d    = 2'd0;
                neg_d     = 1'b0;
                ev_d      = 16'(pend_a_d);
            end
            ACT_CLR: begin
                mag_d     = 8'd0;
                ndig_d    = 2'd0;
                neg_d     = 1'b0;
                pend_a_d  = 8'sd0;
                pend_op_d = 2'd0;
                a_d       = 8'sd0;
                b_d       = 8'sd0;
                op_d      = 2'd0;
                ev_d      = 16'sd0;
            end
            ACT_REJECT: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Working, pending and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q     <= 8'd0;
            ndig_q    <= 2'd0;
            neg_q     <= 1'b0;
            pend_a_q  <= 8'sd0;
            pend_op_q <= 2'd0;
            a_q       <= 8'sd0;
            b_q       <= 8'sd0;
            op_q      <= 2'd0;
            ov_q      <= 1'b0;
            err_q     <= 1'b0;
            ev_q      <= 16'sd0;
        end else begin
            mag_q     <= mag_d;
            ndig_q    <= ndig_d;
            neg_q     <= neg_d;
            pend_a_q  <= pend_a_d;
            pend_op_q <= pend_op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            ov_q      <= ov_d;
            err_q     <= err_d;
            ev_q      <= ev_d;
        end
    end

    assign bus.A              = a_q;
    assign bus.B              = b_q;
    assign bus.opcode         = op_q;
    assign bus.operands_valid = ov_q;
    assign bus.entry_value    = ev_q;
    assign bus.entry_state    = state_q;
    assign bus.key_err        = err_q;

endmodule
